// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd client: default operand width, FSM state
// type and the WAIT counter width helper.
package gcd_pkg;

    localparam int GCD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } gcd_client_state_t;

    // The WAIT counter is at least 16 bits and must hold TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return ($clog2(timeout) > 16) ? $clog2(timeout) : 16;
    endfunction

endpackage

// File: rtl/gcd_req_fifo.sv
// Request queue for the gcd client: DEPTH entries of DW bits, synchronous
// reset, full/empty flags. Push while full and pop while empty are ignored.
module gcd_req_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/gcd_client.sv
// Queues operand pairs, hands them one at a time to an external gcd unit,
// waits (with timeout) for its completion pulse and presents each result
// with a valid/ready handshake, in request order.
module gcd_client
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_a,
    output logic [W-1:0] res_b,
    output logic [W-1:0] res_gcd,
    output logic         res_err,
    output logic         gcd_start,
    output logic [W-1:0] gcd_a,
    output logic [W-1:0] gcd_b,
    input  logic         gcd_ready,
    input  logic         gcd_done_tick,
    input  logic [W-1:0] gcd_out
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    gcd_client_state_t state;
    logic [CW-1:0]     cnt;
    logic [2*W-1:0]    head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // req_ready is forced low while reset is held so nothing is accepted.
    assign req_ready = ~full & ~reset;
    assign push      = req_valid & req_ready;
    assign pop       = (state == IDLE) & ~empty & gcd_ready & ~reset;

    gcd_req_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({req_a, req_b}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Request sequencer: issue, wait with timeout, present result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            gcd_start <= 1'b0;
            gcd_a     <= '0;
            gcd_b     <= '0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_a     <= '0;
            res_b     <= '0;
            res_gcd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        gcd_a     <= head[2*W-1:W];
                        gcd_b     <= head[W-1:0];
                        gcd_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    gcd_start <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion on the last counted cycle still wins.
                    if (gcd_done_tick) begin
                        res_gcd   <= gcd_out;
                        res_err   <= 1'b0;
                        res_a     <= gcd_a;
                        res_b     <= gcd_b;
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else if (cnt == LAST) begin
                        res_gcd   <= '0;
                        res_err   <= 1'b1;
                        res_a     <= gcd_a;
                        res_b     <= gcd_b;
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_client.sv
// Bench for gcd_client with a behavioural gcd unit (optionally silent) and
// a queue-based reference of accepted requests.
module tb_gcd_client;

    localparam int W       = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_a;
    logic [W-1:0] res_b;
    logic [W-1:0] res_gcd;
    logic         res_err;
    logic         gcd_start;
    logic [W-1:0] gcd_a;
    logic [W-1:0] gcd_b;
    logic         gcd_ready;
    logic         gcd_done_tick;
    logic [W-1:0] gcd_out;

    always #5 clk = ~clk;

    gcd_client #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_a         (res_a),
        .res_b         (res_b),
        .res_gcd       (res_gcd),
        .res_err       (res_err),
        .gcd_start     (gcd_start),
        .gcd_a         (gcd_a),
        .gcd_b         (gcd_b),
        .gcd_ready     (gcd_ready),
        .gcd_done_tick (gcd_done_tick),
        .gcd_out       (gcd_out)
    );

    // ---------------- behavioural gcd unit ----------------
    logic         stub_mode  = 1'b0;
    logic         stray_tick = 1'b0;
    logic [W-1:0] stray_val  = 32'hDEAD_BEEF;
    logic         unit_busy  = 1'b0;
    logic         unit_tick  = 1'b0;
    int unsigned  unit_cnt   = 0;
    int unsigned  unit_lat   = 3;
    logic [W-1:0] unit_res   = '0;

    assign gcd_ready     = ~unit_busy;
    assign gcd_done_tick = unit_tick | stray_tick;
    assign gcd_out       = unit_tick ? unit_res : stray_val;

    // Subtractive gcd; a zero operand yields 0 from this unit.
    function automatic logic [W-1:0] unit_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        x = a;
        y = b;
        if (a == '0 || b == '0) return '0;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x;
    endfunction

    // Reference: Euclid by remainder, same zero-operand convention as the unit.
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        if (a == '0 || b == '0) return '0;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Unit: latch operands on gcd_start, pulse done after unit_lat cycles.
    always @(posedge clk) begin
        if (reset) begin
            unit_busy <= 1'b0;
            unit_tick <= 1'b0;
            unit_cnt  <= 0;
        end else begin
            unit_tick <= 1'b0;
            if (!unit_busy) begin
                if (gcd_start) begin
                    unit_busy <= 1'b1;
                    unit_cnt  <= unit_lat;
                    unit_res  <= unit_gcd(gcd_a, gcd_b);
                end
            end else if (unit_cnt > 1) begin
                unit_cnt <= unit_cnt - 1;
            end else begin
                unit_busy <= 1'b0;
                unit_tick <= ~stub_mode;
            end
        end
    end

    // Count gcd_start cycles.
    int unsigned starts = 0;
    always @(posedge clk) begin
        if (gcd_start === 1'b1) starts <= starts + 1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;
    pair_t exp_q[$];

    // Offer a pair (leaves req_valid high); returns at the negedge after acceptance.
    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        int unsigned n;
        pair_t p;
        n = 0;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready === 1'b1);
        if (ok) begin
            @(posedge clk);
            p.a = a;
            p.b = b;
            exp_q.push_back(p);
            @(negedge clk);
        end
    endtask

    // mode 0: normal gcd, 1: timeout (gcd 0, err 1), 2: gcd equals stray_val.
    task automatic take_result(input string tag, input int unsigned hold, input int unsigned mode);
        int unsigned n;
        pair_t p;
        logic [W-1:0] eg;
        logic ee;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, res_valid, 1'b1);
        chk({tag, "_pending"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            p = exp_q.pop_front();
            case (mode)
                1:       begin eg = '0;                ee = 1'b1; end
                2:       begin eg = stray_val;         ee = 1'b0; end
                default: begin eg = ref_gcd(p.a, p.b); ee = 1'b0; end
            endcase
            chk({tag, "_a"},   res_a,   p.a);
            chk({tag, "_b"},   res_b,   p.b);
            chk({tag, "_gcd"}, res_gcd, eg);
            chk({tag, "_err"}, res_err, ee);
        end
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_dropped"}, res_valid, 1'b0);
    endtask

    task automatic wait_start(input string tag);
        int unsigned n;
        n = 0;
        while (gcd_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, gcd_start, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_err"},   res_err,   1'b0);
        chk({tag, "_gcd_start"}, gcd_start, 1'b0);
        chk({tag, "_res_abg"},   {res_a, res_b}, 64'd0);
        chk({tag, "_res_gcd"},   res_gcd,   '0);
        chk({tag, "_gcd_ab"},    {gcd_a, gcd_b}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int unsigned s0;
        int unsigned n;
        int unsigned acc;
        logic [W-1:0] k;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", req_ready, 1'b1);

        // Single request.
        s0 = starts;
        push_pair(32'd6, 32'd15, ok);
        req_valid = 1'b0;
        chk("single_push", ok, 1'b1);
        take_result("single", 0, 0);
        chk("single_starts", starts - s0, 1);

        // In-order queueing, back-to-back.
        s0 = starts;
        push_pair(32'd40, 32'd60, ok);
        chk("order_push0", ok, 1'b1);
        push_pair(32'd128, 32'd64, ok);
        chk("order_push1", ok, 1'b1);
        push_pair(32'd588, 32'd1352, ok);
        chk("order_push2", ok, 1'b1);
        req_valid = 1'b0;
        take_result("order0", 1, 0);
        take_result("order1", 0, 0);
        take_result("order2", 2, 0);
        chk("order_starts", starts - s0, 3);

        // Backpressure with a second request queued and a stray done pulse.
        push_pair(32'd24, 32'd36, ok);
        push_pair(32'd9, 32'd27, ok);
        req_valid = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        s0 = starts;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_gcd", res_gcd, 32'd12);
            chk("bp_ab", {res_a, res_b}, {32'd24, 32'd36});
            chk("bp_nostart", starts, s0);
            stray_tick = (i == 4);
            stray_val  = (i == 4) ? 32'h55 : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        stray_tick = 1'b0;
        stray_val  = 32'hDEAD_BEEF;
        take_result("bp0", 0, 0);
        chk("turnaround_idle", gcd_start, 1'b0);
        @(negedge clk);
        chk("turnaround_issue", gcd_start, 1'b1);
        take_result("bp1", 0, 0);
        chk("bp_starts", starts - s0, 1);

        // Full queue: DEPTH queued plus one in flight.
        unit_lat = 2;
        s0 = starts;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            push_pair(32'(6 * (i + 1)), 32'(9 * (i + 1)), ok);
            if (ok) acc++;
        end
        chk("full_accepted", acc, DEPTH + 1);
        chk("full_ready_low", req_ready, 1'b0);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) take_result("full", 0, 0);
        chk("full_drained", exp_q.size(), 0);
        chk("full_starts", starts - s0, 5);

        // Randomised requests and latencies.
        for (int i = 0; i < 8; i++) begin
            k = 32'($urandom_range(1, 200));
            a = k * 32'($urandom_range(1, 40));
            b = k * 32'($urandom_range(1, 40));
            unit_lat = $urandom_range(1, 10);
            push_pair(a, b, ok);
            req_valid = 1'b0;
            chk("rand_push", ok, 1'b1);
            take_result("rand", $urandom_range(0, 3), 0);
        end

        // Timeout: WAIT lasts TIMEOUT cycles, result in the following cycle.
        stub_mode = 1'b1;
        push_pair(32'd7, 32'd5, ok);
        req_valid = 1'b0;
        wait_start("to");
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, TIMEOUT + 1);
        take_result("to", 0, 1);

        // Completion on the final WAIT cycle counts as success.
        push_pair(32'd10, 32'd4, ok);
        req_valid = 1'b0;
        wait_start("edge");
        repeat (TIMEOUT) @(negedge clk);
        stray_tick = 1'b1;
        stray_val  = 32'hABC;
        @(negedge clk);
        stray_tick = 1'b0;
        take_result("edge", 0, 2);
        stray_val = 32'hDEAD_BEEF;

        // Reset during WAIT discards in-flight and queued work.
        push_pair(32'd8, 32'd12, ok);
        push_pair(32'd3, 32'd3, ok);
        req_valid = 1'b0;
        wait_start("mid");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        exp_q.delete();
        reset = 1'b0;
        stub_mode = 1'b0;
        @(negedge clk);
        chk("mid_release_ready", req_ready, 1'b1);
        s0 = starts;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (res_valid === 1'b1) n++;
            @(negedge clk);
        end
        chk("mid_no_result", n, 0);
        chk("mid_no_start", starts, s0);
        push_pair(32'd1, 32'd0, ok);
        req_valid = 1'b0;
        take_result("post_rst", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_client.md
GCD_CLIENT -- requirements
Module: gcd_client

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the width of operands and result.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of request queue entries (power of two, at least 2).
REQ-003 The block SHALL have parameter TIMEOUT, default 4096, giving the maximum number of cycles to wait for gcd_done_tick.
REQ-004 The block SHALL have these ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  an operand pair is offered.
- req_ready  out  1  the queue can accept a pair.
- req_a  in  W  operand a.
- req_b  in  W  operand b.
- res_valid  out  1  a result is presented.
- res_ready  in  1  the consumer accepts the result.
- res_a  out  W  echo of operand a.
- res_b  out  W  echo of operand b.
- res_gcd  out  W  computed gcd.
- res_err  out  1  the result timed out; res_gcd is invalid.
- gcd_start  out  1  start request to the gcd unit.
- gcd_a  out  W  operand a to the gcd unit.
- gcd_b  out  W  operand b to the gcd unit.
- gcd_ready  in  1  the gcd unit is idle.
- gcd_done_tick  in  1  one-cycle completion pulse from the gcd unit.
- gcd_out  in  W  gcd unit result, valid while gcd_done_tick is high.

Function
REQ-005 A request SHALL be accepted on any cycle where req_valid and req_ready are both high; it is written into a DEPTH-entry FIFO.
REQ-006 req_ready SHALL equal "FIFO not full"; a push while full is not accepted, even if a pop occurs in the same cycle.
REQ-007 The FSM SHALL have four states: IDLE, ISSUE, WAIT, OUT.
REQ-008 IDLE -> ISSUE SHALL occur when the FIFO is non-empty and gcd_ready=1; on that edge the head entry is popped into the operand registers gcd_a and gcd_b.
REQ-009 In ISSUE, gcd_start SHALL be 1 for exactly one cycle, after which the FSM goes to WAIT; gcd_start SHALL be 0 in every other state.
REQ-010 gcd_a and gcd_b SHALL remain stable from ISSUE until the FSM leaves WAIT.
REQ-011 In WAIT, a 16-bit-minimum cycle counter SHALL start from 0; on gcd_done_tick=1, gcd_out SHALL be captured into res_gcd, res_err cleared to 0, and the FSM goes to OUT.
REQ-012 If the WAIT counter reaches TIMEOUT-1 without gcd_done_tick, the block SHALL go to OUT with res_err=1 and res_gcd=0.
REQ-013 If gcd_done_tick arrives on the timeout cycle itself, the block SHALL treat it as success (res_err=0).
REQ-014 In OUT, res_valid SHALL be 1, with res_a, res_b, res_gcd and res_err held stable until res_valid && res_ready; the FSM then goes to IDLE.
REQ-015 Minimum turnaround SHALL be one idle cycle between the OUT handshake and the next ISSUE; results SHALL be returned in request order.
REQ-016 gcd_done_tick seen outside WAIT SHALL be ignored.
REQ-017 gcd_out SHALL be passed through unmodified, including zero operands (for example gcd(0,0) yields whatever the gcd unit returns).

Reset
REQ-018 While reset=1 the block SHALL empty the FIFO, set the FSM to IDLE, clear the counter, and drive req_ready=0, res_valid=0, res_err=0, gcd_start=0, with res_a, res_b, res_gcd, gcd_a and gcd_b all 0.
REQ-019 req_ready SHALL return to 1 in the first cycle after reset deasserts.
REQ-020 Reset asserted in any state, including mid-WAIT, SHALL discard all queued and in-flight work with no result emitted.

Structure
REQ-021 Package gcd_pkg SHALL hold the state enum gcd_client_state_t and the default W.
REQ-022 The FIFO SHALL be a sub-module gcd_req_fifo (2W-bit data, DEPTH entries, full and empty flags, synchronous reset); the FSM and counter stay in gcd_client.

Verification
REQ-023 The bench SHALL cover a single request: push (6,15) with the real gcd unit attached -> one result with res_gcd=3, res_err=0, and res_a/res_b echoing 6/15.
REQ-024 The bench SHALL cover in-order queueing: push (40,60), (128,64), (588,1352) back-to-back -> results 20, 64, 4 in that order, with exactly one gcd_start pulse per request.
REQ-025 The bench SHALL cover backpressure: hold res_ready=0 for 10 cycles in OUT -> outputs stable, no new gcd_start; on release, one handshake.
REQ-026 The bench SHALL cover a full queue: with res_ready=0, push 6 pairs -> req_ready drops after DEPTH+1 accepted (4 queued plus 1 in flight); no pair is lost or duplicated.
REQ-027 The bench SHALL cover timeout: a stub gcd unit that never pulses gcd_done_tick, with TIMEOUT=16 -> res_valid with res_err=1 and res_gcd=0 16 cycles after ISSUE.
REQ-028 The bench SHALL cover reset mid-operation: assert reset during WAIT -> all outputs take their reset values next cycle, no result is emitted, and the next request (1,0) returns 0.
